// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 2-D convolution datapath (feeder and filter sides).
package conv_pkg;

    localparam int unsigned CONV_BW     = 8;
    localparam int unsigned CONV_ROWS   = 8;
    localparam int unsigned CONV_HEIGHT = 2;

    // Ceiling log2 with a floor of 1 so a width derived from it is never zero.
    function automatic int unsigned clogb2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int unsigned CONV_BW_PSUM = 2 * CONV_BW + clogb2(CONV_ROWS);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } feed_state_t;

endpackage

// File: rtl/conv_col_shift.sv
// Height-deep column shift register; col[0] is the oldest column, din enters at col[DEPTH-1].
module conv_col_shift #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [W-1:0]       din,
    output logic [W*DEPTH-1:0] win,
    output logic [W*DEPTH-1:0] win_next
);

    logic [W-1:0] col [DEPTH];
    logic [W-1:0] nxt [DEPTH];

    always_comb begin
        for (int unsigned j = 0; j < DEPTH; j++) nxt[j] = din;
        for (int unsigned j = 0; j + 1 < DEPTH; j++) nxt[j] = col[j+1];
    end

    // win_next exposes the post-shift window so the caller can register it
    // in the same cycle the register itself is cleared for a new frame.
    always_comb begin
        win      = '0;
        win_next = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            win[j*W +: W]      = col[j];
            win_next[j*W +: W] = nxt[j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned j = 0; j < DEPTH; j++) col[j] <= '0;
        end else if (clr) begin
            for (int unsigned j = 0; j < DEPTH; j++) col[j] <= '0;
        end else if (en) begin
            for (int unsigned j = 0; j < DEPTH; j++) col[j] <= nxt[j];
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Sliding-window producer for the convolution filter A input; frames delimited by in_last.
// Optional macro CONV_WIN_PAD_EN: leading zero-padding so every column of a frame emits a window.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int unsigned bw       = CONV_BW,
    parameter int unsigned rows     = CONV_ROWS,
    parameter int unsigned height   = CONV_HEIGHT,
    parameter int unsigned max_cols = 256,
    parameter int unsigned cw       = clogb2(max_cols)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [rows*bw-1:0]         in_col,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [rows*bw*height-1:0]  out_A,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [cw-1:0]              col_idx,
    output logic                       err_ovf
);

    localparam int unsigned COL_W = rows * bw;
    localparam int unsigned FW    = clogb2(height + 1);

    localparam logic [FW-1:0] FILL_FULL = FW'(height);
    localparam logic [FW-1:0] FILL_LAST = FW'(height - 1);
`ifdef CONV_WIN_PAD_EN
    localparam logic [FW-1:0] FILL_INIT = FW'(height - 1);
`else
    localparam logic [FW-1:0] FILL_INIT = '0;
`endif
    localparam logic [cw-1:0] COL_MAX = cw'(max_cols - 1);

    feed_state_t state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [cw-1:0] col_cnt_q, col_cnt_d;
    logic          col_sat_q, col_sat_d;
    logic          ovf_d;
    logic          accept;
    logic          emit;
    logic [COL_W*height-1:0] win_cur;
    logic [COL_W*height-1:0] win_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    conv_col_shift #(
        .W     (COL_W),
        .DEPTH (height)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .en       (accept),
        .clr      (accept && in_last),
        .din      (in_col),
        .win      (win_cur),
        .win_next (win_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FILL;
            fill_q    <= FILL_INIT;
            col_cnt_q <= '0;
            col_sat_q <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            col_cnt_q <= col_cnt_d;
            col_sat_q <= col_sat_d;
            err_ovf   <= ovf_d;
        end
    end

    // col_sat marks that index max_cols-1 has already been consumed, so any
    // further column in the same frame overflows while col_cnt stays saturated.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        col_cnt_d = col_cnt_q;
        col_sat_d = col_sat_q;
        ovf_d     = err_ovf;
        emit      = 1'b0;
        if (accept) begin
            emit = (state_q == STREAM) || (fill_q == FILL_LAST);
            if (col_sat_q) ovf_d = 1'b1;
            if (in_last) begin
                state_d   = FILL;
                fill_d    = FILL_INIT;
                col_cnt_d = '0;
                col_sat_d = 1'b0;
            end else begin
                state_d = emit ? STREAM : FILL;
                fill_d  = emit ? FILL_FULL : fill_q + 1'b1;
                if (col_cnt_q == COL_MAX) col_sat_d = 1'b1;
                else                      col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_A     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            col_idx   <= '0;
        end else if (emit) begin
            out_A     <= win_next;
            out_valid <= 1'b1;
            out_last  <= in_last;
            col_idx   <= col_cnt_q;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    logic unused_win;
    assign unused_win = ^win_cur;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder (rows=8, bw=8, height=2); second instance uses max_cols=4.
module tb_conv_window_feeder;

    logic         clk;
    logic         rst;
    logic [63:0]  in_col;
    logic         in_valid;
    logic         in_last;
    logic         out_ready;

    logic         in_ready;
    logic [127:0] out_A;
    logic         out_valid;
    logic         out_last;
    logic [7:0]   col_idx;
    logic         err_ovf;

    logic         in_ready2;
    logic [127:0] out_A2;
    logic         out_valid2;
    logic         out_last2;
    logic [1:0]   col_idx2;
    logic         err_ovf2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [127:0] got_a[$];
    logic [7:0]   got_idx[$];
    logic         got_last[$];

    conv_window_feeder #(
        .bw(8), .rows(8), .height(2), .max_cols(256)
    ) dut (
        .clk(clk), .rst(rst), .in_col(in_col), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_A(out_A), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .col_idx(col_idx), .err_ovf(err_ovf)
    );

    conv_window_feeder #(
        .bw(8), .rows(8), .height(2), .max_cols(4)
    ) dut_ovf (
        .clk(clk), .rst(rst), .in_col(in_col), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready2), .out_A(out_A2), .out_valid(out_valid2), .out_last(out_last2),
        .out_ready(out_ready), .col_idx(col_idx2), .err_ovf(err_ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            got_a.push_back(out_A);
            got_idx.push_back(col_idx);
            got_last.push_back(out_last);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] win2(input logic [7:0] a, input logic [7:0] b);
        return {{8{b}}, {8{a}}};
    endfunction

    task automatic clear_log();
        got_a.delete();
        got_idx.delete();
        got_last.delete();
    endtask

    task automatic check_win(input string tag, input int unsigned i, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] idx, input logic last);
        if (i < got_a.size()) begin
            check({tag, "_A"}, got_a[i], win2(a, b));
            check({tag, "_idx"}, got_idx[i], idx);
            check({tag, "_last"}, got_last[i], last);
        end else begin
            check({tag, "_missing"}, got_a.size(), i + 1);
        end
    endtask

    // Presents one column and returns at posedge+1 of the cycle it is accepted.
    task automatic send(input logic [7:0] k, input logic last);
        int unsigned n;
        n = 0;
        in_col   = {8{k}};
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_col    = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_A", out_A, 0);
        check("rst_idx", col_idx, 0);
        check("rst_last", out_last, 0);
        check("rst_ovf", err_ovf, 0);
        #9 rst = 1'b1;
        @(posedge clk);
        #1;

`ifdef CONV_WIN_PAD_EN
        clear_log();
        send(8'd1, 1'b0);
        send(8'd2, 1'b1);
        tick(3);
        check("pad_count", got_a.size(), 2);
        check_win("pad_w0", 0, 8'd0, 8'd1, 8'd0, 1'b0);
        check_win("pad_w1", 1, 8'd1, 8'd2, 8'd1, 1'b1);
`else
        clear_log();
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b1);
        tick(3);
        check("fill_count", got_a.size(), 2);
        check_win("fill_w0", 0, 8'd1, 8'd2, 8'd1, 1'b0);
        check_win("fill_w1", 1, 8'd2, 8'd3, 8'd2, 1'b1);

        clear_log();
        send(8'd10, 1'b0);
        send(8'd11, 1'b0);
        out_ready = 1'b0;
        in_col    = {8{8'd12}};
        in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_A", out_A, win2(8'd10, 8'd11));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'd12, 1'b0);
        send(8'd13, 1'b1);
        tick(3);
        check("bp_count", got_a.size(), 3);
        check_win("bp_w0", 0, 8'd10, 8'd11, 8'd1, 1'b0);
        check_win("bp_w1", 1, 8'd11, 8'd12, 8'd2, 1'b0);
        check_win("bp_w2", 2, 8'd12, 8'd13, 8'd3, 1'b1);

        clear_log();
        send(8'd7, 1'b1);
        send(8'd8, 1'b0);
        send(8'd9, 1'b1);
        tick(3);
        check("runt_count", got_a.size(), 1);
        check_win("runt_w0", 0, 8'd8, 8'd9, 8'd1, 1'b1);

        clear_log();
        send(8'd5, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_A", out_A, 0);
        check("mrst_idx", col_idx, 0);
        check("mrst_last", out_last, 0);
        check("mrst_ovf", err_ovf, 0);
        check("mrst_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(8'd6, 1'b0);
        send(8'd7, 1'b1);
        tick(3);
        check("mrst_count", got_a.size(), 1);
        check_win("mrst_w0", 0, 8'd6, 8'd7, 8'd1, 1'b1);
`endif

        send(8'd20, 1'b0);
        send(8'd21, 1'b0);
        send(8'd22, 1'b0);
        send(8'd23, 1'b0);
        check("ovf_4th_flag", err_ovf2, 0);
        check("ovf_4th_idx", col_idx2, 3);
        send(8'd24, 1'b0);
        check("ovf_5th_flag", err_ovf2, 1);
        check("ovf_5th_idx", col_idx2, 3);
        check("ovf_big_flag", err_ovf, 0);
        check("ovf_big_idx", col_idx, 4);
        tick(3);
        check("ovf_sticky", err_ovf2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
